// File: rtl/nem_ohmux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nem_ohmux_pkg
// Description : Shared types, defaults and helpers for the NEM one-hot mux
//               select controller.
// Revision    : 1.0 - initial release
// ============================================================================
package nem_ohmux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAKE  = 2'd2
    } state_e;

    localparam int C_N_IN      = 4;
    localparam int C_BREAK_CYC = 4;
    localparam int C_MAKE_CYC  = 8;

    // Index outside 0..n-1 yields all-zero, which the controller treats as "off".
    function automatic logic [15:0] onehot(input logic [3:0] idx, input int unsigned n);
        logic [15:0] v;
        v = '0;
        if (32'(idx) < n) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nem_ohmux_selctl_if.sv
`default_nettype none
// ============================================================================
// Module      : nem_ohmux_selctl_if
// Description : Request / select bundle between a requester and the selector.
// Revision    : 1.0 - initial release
// ============================================================================
interface nem_ohmux_selctl_if #(
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
);
    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] req_sel;
    logic             req_off;
    logic [N_IN-1:0]  s;
    logic             out_valid;
    logic             busy;
    logic [15:0]      sw_cnt;

    modport master (
        output req_valid, req_sel, req_off,
        input  req_ready, s, out_valid, busy, sw_cnt
    );

    modport slave (
        input  req_valid, req_sel, req_off,
        output req_ready, s, out_valid, busy, sw_cnt
    );
endinterface
`default_nettype wire

// File: rtl/nem_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : nem_dwell_timer
// Description : Loadable down-counter; done while the count sits at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module nem_dwell_timer #(
    parameter int W = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_load,
    input  wire logic [W-1:0] i_load_val,
    output logic              o_done
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/nem_ohmux_selctl.sv
`default_nettype none
// ============================================================================
// Module      : nem_ohmux_selctl
// Description : Break-before-make select sequencer for NEM-relay one-hot mux
//               cells, with saturating actuation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module nem_ohmux_selctl
    import nem_ohmux_pkg::*;
#(
    parameter int N_IN      = C_N_IN,
    parameter int BREAK_CYC = C_BREAK_CYC,
    parameter int MAKE_CYC  = C_MAKE_CYC
) (
    input wire logic           clk,
    input wire logic           rst,
    nem_ohmux_selctl_if.slave  bus
);
    localparam int TW = $clog2(((BREAK_CYC > MAKE_CYC) ? BREAK_CYC : MAKE_CYC) + 1);

    localparam logic [1:0]    c_IDLE   = IDLE;
    localparam logic [1:0]    c_BREAK  = BREAK;
    localparam logic [1:0]    c_MAKE   = MAKE;
    localparam logic [TW-1:0] c_BRK_LD = TW'(BREAK_CYC - 1);
    localparam logic [TW-1:0] c_MK_LD  = TW'(MAKE_CYC - 1);

    logic [1:0]      r_state;
    logic [N_IN-1:0] r_tgt;
    logic [N_IN-1:0] r_s;
    logic            r_ov;
    logic [15:0]     r_sw_cnt;

    logic [1:0]      w_nxt_state;
    logic [N_IN-1:0] w_req_oh;
    logic            w_load;
    logic [TW-1:0]   w_ld_val;
    logic            w_make_ev;
    logic            w_done;

    // All-zero request vector encodes "deselect all" (explicit off or out-of-range index).
    assign w_req_oh = bus.req_off ? '0 : N_IN'(onehot(4'(bus.req_sel), N_IN));

    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_ld_val    = c_BRK_LD;
        w_make_ev   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.req_valid) begin
                    if (w_req_oh == '0) begin
                        if (r_s != '0) begin
                            w_nxt_state = c_BREAK;
                            w_load      = 1'b1;
                        end
                    end else if (w_req_oh != r_s) begin
                        if (r_s == '0) begin
                            w_nxt_state = c_MAKE;
                            w_load      = 1'b1;
                            w_ld_val    = c_MK_LD;
                            w_make_ev   = 1'b1;
                        end else begin
                            w_nxt_state = c_BREAK;
                            w_load      = 1'b1;
                        end
                    end
                end
            end
            c_BREAK: begin
                if (w_done) begin
                    if (r_tgt == '0) begin
                        w_nxt_state = c_IDLE;
                    end else begin
                        w_nxt_state = c_MAKE;
                        w_load      = 1'b1;
                        w_ld_val    = c_MK_LD;
                        w_make_ev   = 1'b1;
                    end
                end
            end
            c_MAKE: begin
                if (w_done) begin
                    w_nxt_state = c_IDLE;
                end
            end
            default: w_nxt_state = c_IDLE;
        endcase
    end

    nem_dwell_timer #(.W(TW)) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_ld_val),
        .o_done     (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_tgt    <= '0;
            r_s      <= '0;
            r_ov     <= 1'b0;
            r_sw_cnt <= '0;
        end else begin
            r_state <= w_nxt_state;
            if ((r_state == c_IDLE) && bus.req_valid) begin
                r_tgt <= w_req_oh;
            end
            // S lags the state by one edge so it only ever steps through zero.
            case (r_state)
                c_BREAK: r_s <= '0;
                c_MAKE:  r_s <= r_tgt;
                default: r_s <= r_s;
            endcase
            if ((r_state == c_MAKE) && (w_nxt_state == c_IDLE)) begin
                r_ov <= 1'b1;
            end else if ((r_state == c_IDLE) && (w_nxt_state != c_IDLE)) begin
                r_ov <= 1'b0;
            end
            if (w_make_ev && (r_sw_cnt != 16'hFFFF)) begin
                r_sw_cnt <= r_sw_cnt + 16'd1;
            end
        end
    end

    assign bus.req_ready = (r_state == c_IDLE);
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.s         = r_s;
    assign bus.out_valid = r_ov;
    assign bus.sw_cnt    = r_sw_cnt;
endmodule
`default_nettype wire
